// File: rtl/life_grid_engine.sv
// Conway's Life engine: double-buffered toroidal cell array, one cell per clock,
// published atomically on SWAP, with a registered cell lookup for the VGA pixel path.
module life_grid_engine #(
  parameter int COLS    = 64,
  parameter int ROWS    = 48,
  parameter int CELL_PX = 10,
  parameter int PERIOD  = 1600,
  parameter int AW      = 12
) (
  input  logic          clock_50,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  input  logic          clear,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic          load_data,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic          pixel_on,
  output logic          busy,
  output logic          gen_done,
  output logic [15:0]   generation,
  output logic [AW:0]   alive_count
);

  localparam int NCELL = COLS * ROWS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_SWAP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NCELL-1:0]  r_buf0, r_buf1;
  logic              r_front_sel;
  logic [AW-1:0]     r_row, r_col;
  logic [IW-1:0]     r_idx;
  logic [AW:0]       r_acc;
  logic [AW:0]       r_alive;
  logic [15:0]       r_gen;
  logic [PW-1:0]     r_period;
  logic              r_pix;

  logic [NCELL-1:0]  w_front;
  logic              w_period_exp;
  logic              w_start;
  logic              w_load_ok;
  logic              w_last;
  logic [AW-1:0]     w_rm, w_rp, w_cm, w_cp;
  logic [7:0]        w_nbr;
  logic [3:0]        w_ncnt;
  logic              w_new;
  logic [9:0]        w_pcol, w_prow;
  logic              w_pix_in;
  logic [IW-1:0]     w_pix_idx;

  function automatic logic [IW-1:0] cidx(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return IW'(r * AW'(COLS) + c);
  endfunction

  function automatic logic [3:0] count8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic life_rule(input logic self, input logic [3:0] n);
    return (n == 4'd3) || (self && (n == 4'd2));
  endfunction

  assign w_front      = r_front_sel ? r_buf1 : r_buf0;
  assign w_period_exp = run && (r_period == PW'(PERIOD - 1));
  assign w_start      = (r_state == S_IDLE) && !clear && (step || w_period_exp);
  assign w_load_ok    = (r_state == S_IDLE) && load_we && !clear &&
                        ({1'b0, load_addr} < (AW+1)'(NCELL));
  assign w_last       = (r_idx == IW'(NCELL - 1));

  // Toroidal neighbour coordinates of the cell being computed
  assign w_rm = (r_row == '0) ? AW'(ROWS - 1) : r_row - AW'(1);
  assign w_rp = (r_row == AW'(ROWS - 1)) ? '0 : r_row + AW'(1);
  assign w_cm = (r_col == '0) ? AW'(COLS - 1) : r_col - AW'(1);
  assign w_cp = (r_col == AW'(COLS - 1)) ? '0 : r_col + AW'(1);

  assign w_nbr = {w_front[cidx(w_rm, w_cm)], w_front[cidx(w_rm, r_col)], w_front[cidx(w_rm, w_cp)],
                  w_front[cidx(r_row, w_cm)],                            w_front[cidx(r_row, w_cp)],
                  w_front[cidx(w_rp, w_cm)], w_front[cidx(w_rp, r_col)], w_front[cidx(w_rp, w_cp)]};
  assign w_ncnt = count8(w_nbr);
  assign w_new  = life_rule(w_front[r_idx], w_ncnt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_last)  w_state_nxt = S_SWAP;
      S_SWAP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (clear) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      if (w_load_ok) begin
        if (r_front_sel) r_buf1[load_addr[IW-1:0]] <= load_data;
        else             r_buf0[load_addr[IW-1:0]] <= load_data;
      end
      if (r_state == S_COMPUTE) begin
        if (r_front_sel) r_buf0[r_idx] <= w_new;
        else             r_buf1[r_idx] <= w_new;
      end
    end
  end

  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) r_period <= '0;
    else if (!run) r_period <= '0;
    else if (r_period == PW'(PERIOD - 1)) r_period <= '0;
    else r_period <= r_period + PW'(1);
  end

  // Publication lands on the edge into SWAP so that generation/alive_count
  // change in the very cycle gen_done is high; front flips before the display reads it.
  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_col       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_alive     <= '0;
      r_gen       <= '0;
      r_front_sel <= 1'b0;
    end else if (clear) begin
      r_alive <= '0;
      r_gen   <= '0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
      r_acc <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_acc <= r_acc + {{AW{1'b0}}, w_new};
      r_idx <= r_idx + IW'(1);
      if (r_col == AW'(COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + AW'(1);
      end else begin
        r_col <= r_col + AW'(1);
      end
      if (w_last) begin
        r_front_sel <= ~r_front_sel;
        r_gen       <= r_gen + 16'd1;
        r_alive     <= r_acc + {{AW{1'b0}}, w_new};
      end
    end
  end

  assign w_pcol    = 10'(int'(x) / CELL_PX);
  assign w_prow    = 10'(int'(y) / CELL_PX);
  assign w_pix_in  = (int'(x) < COLS * CELL_PX) && (int'(y) < ROWS * CELL_PX);
  assign w_pix_idx = cidx(AW'(w_prow), AW'(w_pcol));

  always_ff @(posedge clock_50 or negedge rst_n) begin
    if (!rst_n) r_pix <= 1'b0;
    else        r_pix <= w_pix_in && w_front[w_pix_idx];
  end

  assign pixel_on    = r_pix;
  assign busy        = (r_state != S_IDLE);
  assign gen_done    = (r_state == S_SWAP);
  assign generation  = r_gen;
  assign alive_count = r_alive;

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine on an 8x6 torus: a reference Life model
// predicts each published generation and the pixel map read back through x/y.
module tb_life_grid_engine;

  localparam int C  = 8;
  localparam int R  = 6;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, step = 1'b0, clear = 1'b0, load_we = 1'b0, load_data = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [9:0]    x = '0, y = '0;
  logic          pixel_on, busy, gen_done;
  logic [15:0]   generation;
  logic [AW:0]   alive_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_gen  = 0;

  bit          mdl [R][C];
  logic [22:0] gen_q [$];
  logic        pix_q [$];

  life_grid_engine #(.COLS(C), .ROWS(R), .CELL_PX(10), .PERIOD(100), .AW(AW)) dut (
    .clock_50(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .x(x), .y(y), .pixel_on(pixel_on), .busy(busy), .gen_done(gen_done),
    .generation(generation), .alive_count(alive_count));

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) n += int'(mdl[r][c]);
    return n;
  endfunction

  task automatic model_step();
    bit nx [R][C];
    int n;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0)) n += int'(mdl[(r + dr + R) % R][(c + dc + C) % C]);
        nx[r][c] = (n == 3) || (mdl[r][c] && n == 2);
      end
    mdl = nx;
  endtask

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) mdl[r][c] = 1'b0;
  endtask

  task automatic load_cell(input int r, input int c);
    load_we   = 1'b1;
    load_addr = AW'(r * C + c);
    load_data = 1'b1;
    mdl[r][c] = 1'b1;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    exp_gen = 0;
  endtask

  task automatic check_board(input string nm);
    logic e;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        pix_q.push_back(mdl[r][c]);
        x = 10'(c * 10 + 5);
        y = 10'(r * 10 + 5);
        tick();
        e = pix_q.pop_front();
        n_checks++;
        if (pixel_on !== e) begin
          n_fail++;
          $display("FAIL %s cell(%0d,%0d): pixel_on=%b expected %b", nm, r, c, pixel_on, e);
        end
      end
  endtask

  // One generation; optionally a load coinciding with step, or a load attempted mid-compute
  task automatic do_step(input bit busy_load, input bit co_load, input int co_r, input int co_c);
    int k;
    logic [22:0] e;
    if (co_load) begin
      load_we   = 1'b1;
      load_addr = AW'(co_r * C + co_c);
      load_data = 1'b1;
      mdl[co_r][co_c] = 1'b1;
    end
    step = 1'b1;
    model_step();
    exp_gen++;
    gen_q.push_back({16'(exp_gen), 7'(model_count())});
    tick();
    step    = 1'b0;
    load_we = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_step: busy=%b expected 1", busy); end
    k = 1;
    while (gen_done !== 1'b1 && k < 200) begin
      if (busy_load && k == 10) begin
        load_we   = 1'b1;
        load_addr = AW'(2 * C + 2);
        load_data = 1'b1;
      end
      tick();
      load_we = 1'b0;
      k++;
    end
    n_checks++;
    if (k != C * R + 1) begin n_fail++; $display("FAIL step_latency: gen_done after %0d cycles expected %0d", k, C * R + 1); end
    e = gen_q.pop_front();
    n_checks++;
    if (generation !== e[22:7]) begin n_fail++; $display("FAIL generation: got %0d expected %0d", generation, e[22:7]); end
    n_checks++;
    if (alive_count !== e[6:0]) begin n_fail++; $display("FAIL alive_count: got %0d expected %0d", alive_count, e[6:0]); end
    tick();
    n_checks++;
    if (gen_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL step_end: gen_done=%b busy=%b expected 0 0", gen_done, busy);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({pixel_on, busy, gen_done} !== 3'b000 || generation !== 16'd0 || alive_count !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: pix=%b busy=%b done=%b gen=%0d alive=%0d expected all 0",
               pixel_on, busy, gen_done, generation, alive_count);
    end
    #12 rst_n = 1'b1;
    tick();
    model_clear();
    check_board("reset_board");
  endtask

  task automatic test_blinker();
    load_cell(2, 3); load_cell(2, 4); load_cell(2, 5);
    do_step(1'b0, 1'b0, 0, 0);
    check_board("blinker_vertical");
    do_step(1'b0, 1'b0, 0, 0);
    check_board("blinker_horizontal");
  endtask

  task automatic test_wrap_glider();
    int gr[5] = '{3, 4, 5, 5, 5};
    int gc[5] = '{6, 7, 5, 6, 7};
    do_clear();
    for (int i = 0; i < 5; i++) load_cell(gr[i], gc[i]);
    for (int s = 0; s < 24; s++) begin
      do_step(1'b0, 1'b0, 0, 0);
      n_checks++;
      if (alive_count !== 7'd5) begin n_fail++; $display("FAIL glider_alive step %0d: got %0d expected 5", s, alive_count); end
    end
    model_clear();
    for (int i = 0; i < 5; i++) mdl[(gr[i] + 6) % R][(gc[i] + 6) % C] = 1'b1;
    check_board("glider_displaced");
    do_clear();
    load_cell(0, 0); load_cell(0, 7); load_cell(5, 0); load_cell(5, 7);
    do_step(1'b0, 1'b0, 0, 0);
    check_board("corner_block");
  endtask

  task automatic test_run_mode();
    int  seen = 0;
    bit  stepped = 0;
    do_clear();
    load_cell(2, 3); load_cell(2, 4); load_cell(2, 5);
    run = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (busy === 1'b1 && !stepped) begin step = 1'b1; stepped = 1; end
      tick();
      step = 1'b0;
      if (gen_done === 1'b1) begin
        seen++;
        n_checks++;
        if (generation !== 16'(seen) || alive_count !== 7'd3) begin
          n_fail++;
          $display("FAIL run_gen: gen=%0d alive=%0d expected %0d 3", generation, alive_count, seen);
        end
      end
    end
    run = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gen_done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 10 || generation !== 16'd10) begin
      n_fail++;
      $display("FAIL run_total: gen_done count=%0d generation=%0d expected 10 10", seen, generation);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL run_stop: busy=%b expected 0", busy); end
  endtask

  task automatic test_clear_mid();
    int seen = 0;
    do_clear();
    load_cell(2, 3); load_cell(2, 4); load_cell(2, 5);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (19) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    exp_gen = 0;
    n_checks++;
    if (busy !== 1'b0 || gen_done !== 1'b0 || generation !== 16'd0 || alive_count !== '0) begin
      n_fail++;
      $display("FAIL clear_mid: busy=%b done=%b gen=%0d alive=%0d expected 0 0 0 0",
               busy, gen_done, generation, alive_count);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gen_done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL clear_no_done: gen_done count=%0d expected 0", seen); end
    for (int yy = 0; yy < 70; yy += 3)
      for (int xx = 0; xx < 100; xx += 3) begin
        pix_q.push_back(1'b0);
        x = 10'(xx);
        y = 10'(yy);
        tick();
        n_checks++;
        if (pixel_on !== pix_q.pop_front()) begin
          n_fail++;
          $display("FAIL clear_pixel x=%0d y=%0d: pixel_on=%b expected 0", xx, yy, pixel_on);
        end
      end
  endtask

  task automatic test_load_rules();
    do_clear();
    load_cell(0, 0); load_cell(0, 7); load_cell(5, 0); load_cell(5, 7);
    do_step(1'b1, 1'b0, 0, 0);
    check_board("load_while_busy");
    load_we = 1'b1; load_addr = AW'(48); load_data = 1'b1;
    tick();
    load_addr = AW'(63);
    tick();
    load_we = 1'b0;
    check_board("load_addr_out_of_range");
    load_we = 1'b1; load_addr = AW'(2 * C + 2); load_data = 1'b1; clear = 1'b1;
    tick();
    load_we = 1'b0; clear = 1'b0;
    model_clear();
    exp_gen = 0;
    check_board("load_with_clear");
    load_cell(2, 3); load_cell(2, 4);
    do_step(1'b0, 1'b1, 2, 5);
    check_board("load_with_step");
  endtask

  task automatic test_pixel_map();
    logic e;
    do_clear();
    load_cell(1, 2);
    for (int yy = 0; yy < 70; yy++)
      for (int xx = 0; xx < 100; xx++) begin
        pix_q.push_back((xx >= 20 && xx <= 29 && yy >= 10 && yy <= 19) ? 1'b1 : 1'b0);
        x = 10'(xx);
        y = 10'(yy);
        tick();
        e = pix_q.pop_front();
        n_checks++;
        if (pixel_on !== e) begin
          n_fail++;
          $display("FAIL pixel_map x=%0d y=%0d: pixel_on=%b expected %b", xx, yy, pixel_on, e);
        end
      end
  endtask

  task automatic test_async_reset();
    do_clear();
    load_cell(2, 3); load_cell(2, 4); load_cell(2, 5);
    do_step(1'b0, 1'b0, 0, 0);
    x = 10'd45; y = 10'd25;
    tick();
    n_checks++;
    if (pixel_on !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pixel: pixel_on=%b expected 1", pixel_on); end
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pixel_on, busy, gen_done} !== 3'b000 || generation !== 16'd0 || alive_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: pix=%b busy=%b done=%b gen=%0d alive=%0d expected all 0",
               pixel_on, busy, gen_done, generation, alive_count);
    end
    #3 rst_n = 1'b1;
    tick();
    model_clear();
    exp_gen = 0;
    load_cell(2, 3); load_cell(2, 4); load_cell(2, 5);
    do_step(1'b0, 1'b0, 0, 0);
    check_board("after_reset_gen");
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_wrap_glider();
    test_run_mode();
    test_clear_mid();
    test_load_rules();
    test_pixel_map();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
